// File: rtl/pio_pkg.sv
// Shared PIO definitions: lane count, clock-divider field widths and the
// SMx_CLKDIV[31:8] layout reused by the control register file.
package pio_pkg;

    localparam int NUM_SM        = 4;
    localparam int CLKDIV_INT_W  = 16;
    localparam int CLKDIV_FRAC_W = 8;

    typedef struct packed {
        logic [CLKDIV_INT_W-1:0]  int_part;
        logic [CLKDIV_FRAC_W-1:0] frac_part;
    } clkdiv_t;

endpackage

// File: rtl/pio_clkdiv_lane.sv
// One state machine's fractional clock-enable divider.
// PIO_CLKDIV_FRAC_EN adds the fractional accumulator; without it FRAC is ignored.
module pio_clkdiv_lane
    import pio_pkg::*;
#(
    parameter int INT_W  = CLKDIV_INT_W,
    parameter int FRAC_W = CLKDIV_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [INT_W-1:0]  int_part,
    input  logic [FRAC_W-1:0] frac_part,
    output logic              clk_en
);

    localparam int REM_W = INT_W + 1;
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    logic [REM_W-1:0] remain;
    logic [REM_W-1:0] eff_int;
    logic [REM_W-1:0] reload;
    logic             at_reload;

    // INT=0 encodes the longest divisor, 2^INT_W, hence the extra remain bit.
    assign eff_int   = (int_part == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, int_part};
    assign at_reload = en && (remain == REM_ONE);

`ifdef PIO_CLKDIV_FRAC_EN
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_part};
    assign reload   = eff_int + {{INT_W{1'b0}}, frac_sum[FRAC_W]};

    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            frac_acc <= '0;
        end else if (at_reload) begin
            frac_acc <= frac_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^frac_part;
    assign reload      = eff_int;
`endif

    // Divisor inputs are only looked at on reload, so a period in flight
    // always finishes with the value it started with.
    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            remain <= REM_ONE;
            clk_en <= 1'b0;
        end else if (!en) begin
            clk_en <= 1'b0;
        end else if (at_reload) begin
            remain <= reload;
            clk_en <= 1'b1;
        end else begin
            remain <= remain - REM_ONE;
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/pio_clkdiv.sv
// Per-SM advance-enable generator: NUM_SM independent divider lanes.
// Fractional mode is built only when PIO_CLKDIV_FRAC_EN is defined.
module pio_clkdiv
    import pio_pkg::*;
#(
    parameter int NUM_SM = pio_pkg::NUM_SM,
    parameter int INT_W  = CLKDIV_INT_W,
    parameter int FRAC_W = CLKDIV_FRAC_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SM-1:0]                    sm_en,
    input  logic [NUM_SM-1:0]                    clkdiv_restart,
    input  logic [NUM_SM-1:0][INT_W+FRAC_W-1:0]  fsm_clkdiv,
    output logic [NUM_SM-1:0]                    sm_clk_en
);

    for (genvar i = 0; i < NUM_SM; i++) begin : g_lane
        pio_clkdiv_lane #(
            .INT_W  (INT_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (sm_en[i]),
            .restart   (clkdiv_restart[i]),
            .int_part  (fsm_clkdiv[i][INT_W+FRAC_W-1:FRAC_W]),
            .frac_part (fsm_clkdiv[i][FRAC_W-1:0]),
            .clk_en    (sm_clk_en[i])
        );
    end

endmodule

// File: tb/tb_pio_clkdiv.sv
// Randomized + directed bench for pio_clkdiv with a pulse-schedule reference model
// and an expected-output queue checked by an independent monitor.
module tb_pio_clkdiv;
    import pio_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_SM-1:0]    sm_en;
    logic [NUM_SM-1:0]    clkdiv_restart;
    clkdiv_t [NUM_SM-1:0] fsm_clkdiv;
    logic [NUM_SM-1:0]    sm_clk_en;

    pio_clkdiv dut (
        .clk            (clk),
        .rst            (rst),
        .sm_en          (sm_en),
        .clkdiv_restart (clkdiv_restart),
        .fsm_clkdiv     (fsm_clkdiv),
        .sm_clk_en      (sm_clk_en)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [NUM_SM-1:0] exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     pulse_cnt[NUM_SM];
    longint last_pulse[NUM_SM];
    longint gap[NUM_SM];

    // ---------------- reference model ----------------
    // Each lane is a schedule: en_cnt counts enabled cycles since the last
    // reset/restart, and a pulse is due when en_cnt reaches next_at.
    longint en_cnt[NUM_SM];
    longint next_at[NUM_SM];
    longint frac_total[NUM_SM];

    function automatic longint period_of(int i);
        longint eff;
        longint carry;
        eff = (fsm_clkdiv[i].int_part == 0) ? 65536 : longint'(fsm_clkdiv[i].int_part);
        carry = 0;
`ifdef PIO_CLKDIV_FRAC_EN
        carry = (frac_total[i] + fsm_clkdiv[i].frac_part) / 256 - frac_total[i] / 256;
        frac_total[i] += fsm_clkdiv[i].frac_part;
`endif
        return eff + carry;
    endfunction

    task automatic model_step();
        logic [NUM_SM-1:0] e;
        e = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (!rst || clkdiv_restart[i]) begin
                en_cnt[i] = 0;
                next_at[i] = 0;
                frac_total[i] = 0;
            end else if (sm_en[i]) begin
                if (en_cnt[i] == next_at[i]) begin
                    e[i] = 1'b1;
                    next_at[i] += period_of(i);
                end
                en_cnt[i]++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Apply the currently set inputs for one clock.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_SM; i++) begin
            pulse_cnt[i] = 0;
            last_pulse[i] = -1;
            gap[i] = 0;
        end
    endtask

    task automatic chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic set_div(int i, int ip, int fp);
        fsm_clkdiv[i].int_part  = 16'(ip);
        fsm_clkdiv[i].frac_part = 8'(fp);
    endtask

    task automatic random_other_lanes(logic [NUM_SM-1:0] keep);
        for (int i = 0; i < NUM_SM; i++) begin
            if (!keep[i]) begin
                sm_en[i] = ($urandom_range(0, 7) != 0);
                clkdiv_restart[i] = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 31) == 0) set_div(i, $urandom_range(1, 9), $urandom_range(0, 255));
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [NUM_SM-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (sm_clk_en !== e) begin
                    errors++;
                    $display("FAIL sm_clk_en @cycle %0d: got %b expected %b", cyc, sm_clk_en, e);
                end
                for (int i = 0; i < NUM_SM; i++) begin
                    if (sm_clk_en[i] === 1'b1) begin
                        pulse_cnt[i]++;
                        if (last_pulse[i] >= 0) gap[i] = cyc - last_pulse[i];
                        last_pulse[i] = cyc;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        int lane1_exp;
        clear_counts();
        rst = 1'b0;
        sm_en = '1;
        clkdiv_restart = '0;
        for (int i = 0; i < NUM_SM; i++) set_div(i, 1, 0);

        // Reset, then full rate on every lane.
        steps(3);
        chk("pulses_during_reset", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
        rst = 1'b1;
        clear_counts();
        steps(20);
        for (int i = 0; i < NUM_SM; i++) chk($sformatf("full_rate_lane%0d", i), pulse_cnt[i], 20);

        // Integer divide on SM0, fractional divide on SM1.
        set_div(0, 3, 0);
        set_div(1, 2, 8'h80);
        sm_en = 4'b0011;
        clkdiv_restart = 4'b0011;
        step();
        clkdiv_restart = '0;
        clear_counts();
        steps(90);
        chk("int_div3_90cyc", pulse_cnt[0], 30);
        chk("int_div3_gap", gap[0], 3);
        steps(160);
        chk("int_div3_250cyc", pulse_cnt[0], 84);
`ifdef PIO_CLKDIV_FRAC_EN
        lane1_exp = 100;
`else
        lane1_exp = 125;
`endif
        chk("frac_div_250cyc", pulse_cnt[1], lane1_exp);

        // Restart SM3 mid-period while other lanes keep running.
        set_div(3, 10, 0);
        sm_en = 4'b1011;
        clkdiv_restart = 4'b1000;
        step();
        clkdiv_restart = '0;
        steps(4);
        clear_counts();
        clkdiv_restart = 4'b1000;
        step();
        chk("restart_no_pulse", pulse_cnt[3], 0);
        clkdiv_restart = '0;
        steps(11);
        chk("restart_pulses", pulse_cnt[3], 2);
        chk("restart_period", gap[3], 10);

        // Enable gating on SM0 with INT=5.
        set_div(0, 5, 0);
        clkdiv_restart = 4'b0001;
        step();
        clkdiv_restart = '0;
        steps(3);
        sm_en[0] = 1'b0;
        clear_counts();
        steps(20);
        chk("gated_no_pulse", pulse_cnt[0], 0);
        sm_en[0] = 1'b1;
        steps(2);
        chk("gated_early", pulse_cnt[0], 0);
        step();
        chk("gated_resume", pulse_cnt[0], 1);

        // Divide by 65536 on SM2 while other lanes are randomized.
        set_div(2, 0, 0);
        sm_en[2] = 1'b1;
        clkdiv_restart = 4'b0100;
        step();
        clkdiv_restart = '0;
        clear_counts();
        for (int k = 0; k < 65538; k++) begin
            random_other_lanes(4'b0100);
            step();
        end
        chk("div65536_pulses", pulse_cnt[2], 2);
        chk("div65536_period", gap[2], 65536);

        // Fully random phase including occasional mid-period reset.
        for (int i = 0; i < NUM_SM; i++) set_div(i, $urandom_range(1, 9), $urandom_range(0, 255));
        for (int k = 0; k < 3000; k++) begin
            random_other_lanes('0);
            rst = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1'b1;
        sm_en = '0;
        clkdiv_restart = '0;

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
